// File: rtl/led_pkg.sv
// led_pkg: constants shared by the LED fade output stage.
// State encoding, system clock rate and default ramp rate.
package led_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_UP   = 2'd1,
    ST_ON   = 2'd2,
    ST_DOWN = 2'd3
  } led_st_t;

  localparam int CLK_HZ = 50_000_000;

  // ~250 ms for a full 8-bit ramp at CLK_HZ
  localparam int RAMP_STEP_DEFAULT = 48_828;

endpackage

// File: rtl/led_pwm_gen.sv
// led_pwm_gen: free-running PWM with duty latched at period boundary.
// Duty changes only take effect at the start of a new period.
module led_pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic [PWM_BITS-1:0] duty,
  output logic                LED_Out
);

  localparam logic [PWM_BITS-1:0] CNT_ONE = PWM_BITS'(1);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] applied_duty;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pwm_cnt      <= '0;
      applied_duty <= '0;
      LED_Out      <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + CNT_ONE;
      if (&pwm_cnt)
        applied_duty <= duty;
      LED_Out <= (pwm_cnt < applied_duty);
    end
  end

endmodule

// File: rtl/led_fade_driver.sv
// led_fade_driver: turns an on/off request into a linear PWM fade.
// FSM and prescaler walk duty toward target one LSB per step.
module led_fade_driver
  import led_pkg::*;
#(
  parameter int PWM_BITS       = 8,
  parameter int RAMP_STEP_CLKS = RAMP_STEP_DEFAULT,
  parameter int STEP_CNT_W     = 28
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                LED_In,
  input  logic [PWM_BITS-1:0] Brightness,
  output logic                LED_Out,
  output logic                Busy,
  output logic [PWM_BITS-1:0] Duty
);

  localparam logic [PWM_BITS-1:0] D_ONE = PWM_BITS'(1);
  localparam logic [STEP_CNT_W-1:0] S_ONE = STEP_CNT_W'(1);
  localparam logic [STEP_CNT_W-1:0] S_LAST =
    STEP_CNT_W'(RAMP_STEP_CLKS - 1);

  led_st_t               state;
  logic [PWM_BITS-1:0]   duty;
  logic [PWM_BITS-1:0]   target;
  logic [PWM_BITS-1:0]   duty_inc;
  logic [PWM_BITS-1:0]   duty_dec;
  logic [STEP_CNT_W-1:0] step_cnt;
  logic                  tick;

  assign target   = LED_In ? Brightness : '0;
  assign duty_inc = duty + D_ONE;
  assign duty_dec = duty - D_ONE;
  assign tick     = (step_cnt == S_LAST);
  assign Duty     = duty;

  // step_cnt defaults to 0 so every state change restarts the prescaler
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= ST_OFF;
      duty     <= '0;
      step_cnt <= '0;
      Busy     <= 1'b0;
    end else begin
      step_cnt <= '0;
      unique case (state)
        ST_OFF: begin
          if (target != '0) begin
            state <= ST_UP;
            Busy  <= 1'b1;
          end
        end
        ST_UP: begin
          if (target < duty) begin
            state <= ST_DOWN;
          end else if (target == duty) begin
            state <= ST_ON;
            Busy  <= 1'b0;
          end else if (tick) begin
            duty <= duty_inc;
            if (duty_inc == target) begin
              state <= ST_ON;
              Busy  <= 1'b0;
            end
          end else begin
            step_cnt <= step_cnt + S_ONE;
          end
        end
        ST_ON: begin
          if (target < duty) begin
            state <= ST_DOWN;
            Busy  <= 1'b1;
          end else if (target > duty) begin
            state <= ST_UP;
            Busy  <= 1'b1;
          end
        end
        ST_DOWN: begin
          if (target > duty) begin
            state <= ST_UP;
          end else if (target == duty) begin
            state <= (duty == '0) ? ST_OFF : ST_ON;
            Busy  <= 1'b0;
          end else if (tick) begin
            duty <= duty_dec;
            if (duty_dec == target) begin
              state <= (target == '0) ? ST_OFF : ST_ON;
              Busy  <= 1'b0;
            end
          end else begin
            step_cnt <= step_cnt + S_ONE;
          end
        end
      endcase
    end
  end

  led_pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .duty   (duty),
    .LED_Out(LED_Out)
  );

endmodule
